piso_tx: RTL
============

# piso_tx

Parallel-in, serial-out transmitter. It is the outbound counterpart of the datapath's parallel load registers: it captures one WIDTH-bit word on a load strobe and shifts it out one bit per clock, framed by a strobe. A receiving SIPO can rebuild the word from that stream. It sits at the edge of the datapath and serialises result words for off-block transfer.

## Interface

Parameters:
- WIDTH, 32, word length in bits; legal range is WIDTH ≥ 2.
- LSB_FIRST, 1, bit order: 1 sends din[0] first, 0 sends din[WIDTH-1] first.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  WIDTH  parallel word to transmit.
- ld  input  1  load request; sampled on the rising edge.
- busy  output  1  high while a word is being shifted; ld is ignored while high.
- sdo  output  1  serial data out; registered.
- sfrm  output  1  frame strobe; high exactly while sdo carries valid bits.
- done  output  1  one-cycle pulse after the last bit of a word.

## Operation

- State machine with three states: IDLE, SHIFT, DONE.
- All outputs are registered or decoded from state registers. There are no combinational paths from din or ld to any output.
- IDLE:
  - busy=0, sfrm=0, sdo=0, done=0.
  - If ld=1 at an edge: capture din into the shift register, clear the bit counter, and go to SHIFT.
- SHIFT:
  - busy=1, sfrm=1.
  - sdo presents the current head bit of the shift register.
  - Each edge shifts the register by one toward the output end and increments the counter.
  - Once WIDTH bits have been presented (counter reaches WIDTH-1 at an edge), go to DONE.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0, sfrm=0, sdo=0.
  - An ld=1 at the edge leaving DONE is accepted: capture and go to SHIFT, giving back-to-back frames with a one-cycle gap.
  - With ld=0, go to IDLE.
- Bit counter width is $clog2(WIDTH). No wrap occurs, because the counter is reset on every load.
- ld in SHIFT is ignored. It is neither queued nor latched, and din changes during SHIFT have no effect.
- Reset, asserted at any time including mid-frame:
  - Immediately forces IDLE and clears the shift register and counter.
  - Outputs go to busy=0, sfrm=0, sdo=0, done=0.
  - The partial frame is abandoned; a receiver sees sfrm drop early.
- Reset release is taken synchronously. The first ld can be accepted on the first rising edge after rst_n goes high.

## Timing

- Cycle numbering: ld=1 is sampled in IDLE at edge k; "cycle k+n" is the interval after edge k+n-1.
- Cycles k+1 .. k+WIDTH:
  - sfrm=1 and busy=1.
  - sdo carries bit 0,1,…,WIDTH-1 when LSB_FIRST=1, or bit WIDTH-1 … 0 when LSB_FIRST=0.
- Cycle k+WIDTH+1: done=1, busy=0, sfrm=0.
- Latency from load edge to first bit is 1 cycle. A frame is WIDTH cycles; load-to-done is WIDTH+1 cycles.
- Sustained throughput is one word per WIDTH+1 cycles: ld held high continuously reloads at every DONE edge.
- Simultaneous ld=1 with rst_n=0: reset wins and nothing is captured.

## Test plan

- Reset values: assert rst_n=0 mid-simulation with ld=1 and din=32'hFFFF_FFFF. Required: busy=0, sfrm=0, sdo=0 and done=0 immediately, asynchronously and without waiting for clk.
- Basic LSB-first frame: WIDTH=32, din=32'hA5A5_0F01, one-cycle ld pulse.
  - sdo in cycles k+1..k+16 must be 1,0,0,0,0,0,0,0,1,1,1,1,0,0,0,0.
  - sfrm=1 for exactly 32 cycles.
  - done=1 only in cycle k+33.
- MSB-first: LSB_FIRST=0, din=32'h8000_0001. Required: sdo=1 in cycle k+1, 0 in cycles k+2..k+31, and 1 in cycle k+32.
- Ignored load: issue ld=1 with din=32'h1234_5678 during SHIFT of word 32'h0000_0000. Required: sdo stays 0 for all 32 bits, and no second frame starts after done.
- Back-to-back: hold ld=1 with din=32'hFFFF_FFFF.
  - Frames repeat every 33 cycles.
  - sfrm is low for exactly one cycle (the DONE cycle) between frames.
  - done pulses once per frame.
- Mid-frame reset: assert rst_n=0 at bit 10 of a frame, release it, then load 32'h0000_0003.
  - Required: sfrm drops at once.
  - The new frame's first two bits are 1,1 followed by 30 zeros, with no residue from the aborted word.

Source files
------------

// File: rtl/piso_tx.sv
// Parallel-in, serial-out transmitter: loads a WIDTH-bit word on ld and shifts it
// out one bit per clock, framed by sfrm, followed by a one-cycle done pulse.
module piso_tx #(
    parameter int WIDTH     = 32,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             ld,
    output logic             busy,
    output logic             sdo,
    output logic             sfrm,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] cnt_reg;

    logic [WIDTH-1:0] shifted;
    logic             head_din;
    logic             head_shifted;

    // The output end is bit 0 for LSB-first and bit WIDTH-1 for MSB-first.
    assign shifted      = LSB_FIRST ? (shift_reg >> 1) : (shift_reg << 1);
    assign head_din     = LSB_FIRST ? din[0] : din[WIDTH-1];
    assign head_shifted = LSB_FIRST ? shifted[0] : shifted[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            cnt_reg   <= '0;
            busy      <= 1'b0;
            sfrm      <= 1'b0;
            sdo       <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (ld) begin
                        // sdo is registered, so the first bit comes straight from din.
                        shift_reg <= din;
                        cnt_reg   <= '0;
                        state_reg <= SHIFT;
                        busy      <= 1'b1;
                        sfrm      <= 1'b1;
                        sdo       <= head_din;
                    end else begin
                        state_reg <= IDLE;
                        busy      <= 1'b0;
                        sfrm      <= 1'b0;
                        sdo       <= 1'b0;
                    end
                end
                SHIFT: begin
                    shift_reg <= shifted;
                    if (cnt_reg == LAST_BIT) begin
                        state_reg <= DONE;
                        busy      <= 1'b0;
                        sfrm      <= 1'b0;
                        sdo       <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                        sdo     <= head_shifted;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy      <= 1'b0;
                    sfrm      <= 1'b0;
                    sdo       <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule
